// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID/EX boundary: field bundle, interlock
// states, the bubble encoding and opcode helpers.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_REG_AW = 5;

    // Opcode encodings mirror the core's existing opcode include
    localparam logic [5:0] OP_CODE_RR   = 6'h00;
    localparam logic [5:0] OP_CODE_BEQ  = 6'h04;
    localparam logic [5:0] OP_CODE_BNE  = 6'h05;
    localparam logic [5:0] OP_CODE_ADDI = 6'h08;
    localparam logic [5:0] OP_CODE_LW   = 6'h23;
    localparam logic [5:0] OP_CODE_SW   = 6'h2b;

    // Interlock state: RUN loads normally, STALL follows an inserted bubble
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } id_ex_state_t;

    // Register indices: [0]=rs, [1]=rt, [2]=dest
    typedef logic [2:0][PIPE_REG_AW-1:0] layer_t;

    typedef struct packed {
        logic [5:0]             op;
        logic [5:0]             funct;
        layer_t                 layer;
        logic [PIPE_DATA_W-1:0] rs_data;
        logic [PIPE_DATA_W-1:0] rt_data;
        logic [PIPE_DATA_W-1:0] imm;
    } id_ex_fields_t;

    // Bubble is "sll $0,$0,0": RR opcode with every other field zero
    localparam id_ex_fields_t BUBBLE = '{
        op:      OP_CODE_RR,
        funct:   6'd0,
        layer:   '0,
        rs_data: '0,
        rt_data: '0,
        imm:     '0
    };

    // Opcodes whose rt field is a source register rather than a destination
    function automatic logic reads_rt(input logic [5:0] op);
        logic r;
        r = 1'b0;
        unique case (op)
            OP_CODE_RR,
            OP_CODE_SW,
            OP_CODE_BEQ,
            OP_CODE_BNE: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use compare between the instruction in EX and the one
// in ID; also used by the MCU-side hazard checks.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = PIPE_REG_AW
) (
    input  logic              ex_valid,
    input  logic [5:0]        ex_op,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic              id_valid,
    input  logic [5:0]        id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              hit
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // A load into $0 never creates a dependency; rt only counts when read
    always_comb begin
        ex_is_load = ex_valid && (ex_op == OP_CODE_LW) && (ex_dest != '0);
        rs_match   = (ex_dest == id_rs);
        rt_match   = reads_rt(id_op) && (ex_dest == id_rt);
        hit        = id_valid && ex_is_load && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a one-bubble load-use interlock.
// Optional ID_EX_STALL_CNT_EN adds a saturating stall_cnt output.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned REG_AW = PIPE_REG_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [5:0]             id_op_code,
    input  logic [5:0]             id_funct,
    input  logic [2:0][REG_AW-1:0] id_layer,
    input  logic [DATA_W-1:0]      id_rs_data,
    input  logic [DATA_W-1:0]      id_rt_data,
    input  logic [DATA_W-1:0]      id_imm_ext,
    input  logic                   ex_hold,
    input  logic                   flush,
    output logic                   ex_valid,
    output logic [5:0]             op_code_ex,
    output logic [5:0]             funct_ex,
    output logic [2:0][REG_AW-1:0] layer_EX,
    output logic [DATA_W-1:0]      rs_data_ex,
    output logic [DATA_W-1:0]      rt_data_ex,
    output logic [DATA_W-1:0]      imm_ex,
    output logic                   id_stall
`ifdef ID_EX_STALL_CNT_EN
   ,output logic [31:0]            stall_cnt
`endif
);

    id_ex_fields_t fields_q;
    id_ex_fields_t fields_d;
    id_ex_fields_t id_fields;
    logic          ex_valid_q;
    logic          ex_valid_d;
    id_ex_state_t  state_q;
    id_ex_state_t  state_d;
    logic          hazard;
    logic          bubble_ins;

    // Bundle the ID-side fields the same way the EX register stores them
    always_comb begin
        id_fields         = BUBBLE;
        id_fields.op      = id_op_code;
        id_fields.funct   = id_funct;
        id_fields.layer   = id_layer;
        id_fields.rs_data = id_rs_data;
        id_fields.rt_data = id_rt_data;
        id_fields.imm     = id_imm_ext;
    end

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .ex_valid (ex_valid_q),
        .ex_op    (fields_q.op),
        .ex_dest  (fields_q.layer[2]),
        .id_valid (id_valid),
        .id_op    (id_op_code),
        .id_rs    (id_layer[0]),
        .id_rt    (id_layer[1]),
        .hit      (hazard)
    );

    // Next-state selection: flush beats hold, hold beats interlock
    always_comb begin
        fields_d   = fields_q;
        ex_valid_d = ex_valid_q;
        state_d    = state_q;
        id_stall   = 1'b0;
        bubble_ins = 1'b0;
        if (flush) begin
            fields_d   = BUBBLE;
            ex_valid_d = 1'b0;
            state_d    = RUN;
        end else if (ex_hold) begin
            id_stall = 1'b1;
        end else if ((state_q == RUN) && hazard) begin
            fields_d   = BUBBLE;
            ex_valid_d = 1'b0;
            state_d    = STALL;
            id_stall   = 1'b1;
            bubble_ins = 1'b1;
        end else begin
            // After a bubble EX is empty, so ID loads unconditionally
            fields_d   = id_valid ? id_fields : BUBBLE;
            ex_valid_d = id_valid;
            state_d    = RUN;
        end
    end

    // EX register and interlock state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fields_q   <= BUBBLE;
            ex_valid_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            fields_q   <= fields_d;
            ex_valid_q <= ex_valid_d;
            state_q    <= state_d;
        end
    end

    // Drive the EX-side outputs straight from the register
    always_comb begin
        ex_valid   = ex_valid_q;
        op_code_ex = fields_q.op;
        funct_ex   = fields_q.funct;
        layer_EX   = fields_q.layer;
        rs_data_ex = fields_q.rs_data;
        rt_data_ex = fields_q.rt_data;
        imm_ex     = fields_q.imm;
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Count inserted load-use bubbles, sticking at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble_ins && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_bubble;
    assign unused_bubble = bubble_ins;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued at
// stimulus time and compared one edge later.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int K_LOAD = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;
    localparam logic [5:0] FN_ADD = 6'h20;

    typedef struct packed {
        logic          valid;
        id_ex_fields_t f;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [5:0]       id_op_code;
    logic [5:0]       id_funct;
    logic [2:0][4:0]  id_layer;
    logic [31:0]      id_rs_data;
    logic [31:0]      id_rt_data;
    logic [31:0]      id_imm_ext;
    logic             ex_hold;
    logic             flush;
    logic             ex_valid;
    logic [5:0]       op_code_ex;
    logic [5:0]       funct_ex;
    logic [2:0][4:0]  layer_EX;
    logic [31:0]      rs_data_ex;
    logic [31:0]      rt_data_ex;
    logic [31:0]      imm_ex;
    logic             id_stall;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]      stall_cnt;
    int               exp_cnt;
`endif

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    exp_t last;

    id_ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_op_code (id_op_code),
        .id_funct   (id_funct),
        .id_layer   (id_layer),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm_ext (id_imm_ext),
        .ex_hold    (ex_hold),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .op_code_ex (op_code_ex),
        .funct_ex   (funct_ex),
        .layer_EX   (layer_EX),
        .rs_data_ex (rs_data_ex),
        .rt_data_ex (rt_data_ex),
        .imm_ex     (imm_ex),
        .id_stall   (id_stall)
`ifdef ID_EX_STALL_CNT_EN
       ,.stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp_ex(input string tag, input exp_t e);
        chk({tag, ".valid"}, ex_valid, e.valid);
        chk({tag, ".op"}, op_code_ex, e.f.op);
        chk({tag, ".funct"}, funct_ex, e.f.funct);
        chk({tag, ".layer"}, layer_EX, e.f.layer);
        chk({tag, ".rs"}, rs_data_ex, e.f.rs_data);
        chk({tag, ".rt"}, rt_data_ex, e.f.rt_data);
        chk({tag, ".imm"}, imm_ex, e.f.imm);
    endtask

    task automatic step(input string tag, input logic v,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] dst, input logic [4:0] rt,
                        input logic [4:0] rs, input logic hold,
                        input logic fl, input logic exp_stall,
                        input int kind);
        exp_t          e;
        id_ex_fields_t idf;
        @(negedge clk);
        id_valid   = v;
        id_op_code = op;
        id_funct   = fn;
        id_layer   = {dst, rt, rs};
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm_ext = $urandom;
        ex_hold    = hold;
        flush      = fl;
        idf = '{op: op, funct: fn, layer: {dst, rt, rs},
                rs_data: id_rs_data, rt_data: id_rt_data,
                imm: id_imm_ext};
        #1;
        chk({tag, ".stall"}, id_stall, exp_stall);
        e = last;
        if (kind == K_LOAD) begin
            e.valid = v;
            e.f     = v ? idf : BUBBLE;
        end else if (kind == K_BUB) begin
            e.valid = 1'b0;
            e.f     = BUBBLE;
        end
`ifdef ID_EX_STALL_CNT_EN
        if (kind == K_BUB && exp_stall) exp_cnt++;
`endif
        sb.push_back(e);
        last = e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            cmp_ex(tag, e);
        end
`ifdef ID_EX_STALL_CNT_EN
        chk({tag, ".cnt"}, stall_cnt, exp_cnt);
`endif
    endtask

    task automatic idle_inputs();
        id_valid   = 1'b0;
        id_op_code = OP_CODE_RR;
        id_funct   = '0;
        id_layer   = '0;
        id_rs_data = '0;
        id_rt_data = '0;
        id_imm_ext = '0;
        ex_hold    = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        e.valid = 1'b0;
        e.f     = BUBBLE;
        cmp_ex({tag, ".async"}, e);
        chk({tag, ".stall"}, id_stall, 0);
        @(posedge clk);
        #1;
        cmp_ex(tag, e);
`ifdef ID_EX_STALL_CNT_EN
        exp_cnt = 0;
        chk({tag, ".cnt"}, stall_cnt, 0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        last = e;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef ID_EX_STALL_CNT_EN
        exp_cnt = 0;
`endif
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset("rst0");

        // Load-use on rs: one bubble, then ADD with layer {9,3,8}
        step("lw8",   1, OP_CODE_LW,   0,      8, 0,  29, 0, 0, 0, K_LOAD);
        step("add_h", 1, OP_CODE_RR,   FN_ADD, 9, 3,  8,  0, 0, 1, K_BUB);
        step("add_r", 1, OP_CODE_RR,   FN_ADD, 9, 3,  8,  0, 0, 0, K_LOAD);
        // ADDI's rt is a destination, so no interlock
        step("lw8b",  1, OP_CODE_LW,   0,      8, 0,  29, 0, 0, 0, K_LOAD);
        step("addi",  1, OP_CODE_ADDI, 0,      9, 8,  10, 0, 0, 0, K_LOAD);
        // Load into $0 never interlocks
        step("lw0",   1, OP_CODE_LW,   0,      0, 0,  29, 0, 0, 0, K_LOAD);
        step("add0",  1, OP_CODE_RR,   FN_ADD, 9, 0,  0,  0, 0, 0, K_LOAD);
        // SW reads rt
        step("lw5",   1, OP_CODE_LW,   0,      5, 0,  29, 0, 0, 0, K_LOAD);
        step("sw_h",  1, OP_CODE_SW,   0,      0, 5,  2,  0, 0, 1, K_BUB);
        step("sw_r",  1, OP_CODE_SW,   0,      0, 5,  2,  0, 0, 0, K_LOAD);
        // Flush wins over a simultaneous hazard
        step("lw7",   1, OP_CODE_LW,   0,      7, 0,  29, 0, 0, 0, K_LOAD);
        step("beq_f", 1, OP_CODE_BEQ,  0,      0, 7,  1,  0, 1, 0, K_BUB);
        step("nop",   0, OP_CODE_RR,   0,      0, 0,  0,  0, 0, 0, K_LOAD);
        // Invalid ID slot does not interlock
        step("lw2",   1, OP_CODE_LW,   0,      2, 0,  29, 0, 0, 0, K_LOAD);
        step("inv",   0, OP_CODE_RR,   FN_ADD, 9, 2,  2,  0, 0, 0, K_LOAD);
        // Three held cycles keep EX, then the hazard resolves
        step("lw4",   1, OP_CODE_LW,   0,      4, 0,  29, 0, 0, 0, K_LOAD);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1, OP_CODE_RR, FN_ADD, 9, 1, 4, 1, 0, 1, K_HOLD);
        end
        step("add4h", 1, OP_CODE_RR,   FN_ADD, 9, 1,  4,  0, 0, 1, K_BUB);
        step("add4r", 1, OP_CODE_RR,   FN_ADD, 9, 1,  4,  0, 0, 0, K_LOAD);
        // Hold while in STALL stays stalled, then loads
        step("lw6",   1, OP_CODE_LW,   0,      6, 0,  29, 0, 0, 0, K_LOAD);
        step("bne_h", 1, OP_CODE_BNE,  0,      0, 6,  1,  0, 0, 1, K_BUB);
        step("shold", 1, OP_CODE_BNE,  0,      0, 6,  1,  1, 0, 1, K_HOLD);
        step("bne_r", 1, OP_CODE_BNE,  0,      0, 6,  1,  0, 0, 0, K_LOAD);
        // Reset in the middle of a stall
        step("lw3",   1, OP_CODE_LW,   0,      3, 0,  29, 0, 0, 0, K_LOAD);
        step("add3h", 1, OP_CODE_RR,   FN_ADD, 9, 1,  3,  0, 0, 1, K_BUB);
        do_reset("rst1");
        step("add3r", 1, OP_CODE_RR,   FN_ADD, 9, 1,  3,  0, 0, 0, K_LOAD);
        step("tail",  0, OP_CODE_RR,   0,      0, 0,  0,  0, 0, 0, K_LOAD);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
